// File: rtl/sram_axi_arbiter_pkg.sv
// sram_axi_arbiter_pkg: shared state, size, ID and stall-bus definitions for the SRAM-to-AXI arbiter
package sram_axi_arbiter_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR_DATA,
    S_WR_RESP
  } state_e;
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INST,
    OWN_DATA
  } owner_e;
  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;
  localparam logic [3:0] INST_ID_DEF = 4'd0;
  localparam logic [3:0] DATA_ID_DEF = 4'd1;
  localparam int unsigned STALL_BUS_W = 6;
  localparam int unsigned STALL_IDX_SRAM = 0;
  function automatic logic [2:0] ax_size(input logic [1:0] s);
    return s == 2'd0 ? SIZE_BYTE : s == 2'd1 ? SIZE_HALF : SIZE_WORD;
  endfunction
endpackage

// File: rtl/sram_axi_arbiter_wr_channel.sv
// axi_wr_channel: runs the independent aw/w handshakes, then waits for b and pulses done
module axi_wr_channel (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic awready_i,
  input  logic wready_i,
  input  logic bvalid_i,
  output logic awvalid_o,
  output logic wvalid_o,
  output logic bready_o,
  output logic addr_done_o,
  output logic done_o
);
  logic aw_q, w_q, b_q;
  // both address and data phases finish this cycle; done fires on the response handshake
  always_comb begin
    awvalid_o   = aw_q;
    wvalid_o    = w_q;
    bready_o    = b_q;
    addr_done_o = (aw_q | w_q) & (~aw_q | awready_i) & (~w_q | wready_i);
    done_o      = b_q & bvalid_i;
  end
  // each valid drops on its own handshake; bready rises once both have completed
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_q <= 1'b0;
      w_q  <= 1'b0;
      b_q  <= 1'b0;
    end else begin
      aw_q <= start_i | (aw_q & ~awready_i);
      w_q  <= start_i | (w_q & ~wready_i);
      b_q  <= addr_done_o | (b_q & ~bvalid_i);
    end
  end
endmodule

// File: rtl/sram_axi_arbiter.sv
// sram_axi_arbiter: shares one AXI master port between fetch and data SRAM-like requesters
module sram_axi_arbiter
  import sram_axi_arbiter_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ready,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ready,
  output logic        stallreq,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);
  state_e      state_q, state_d;
  owner_e      owner_q;
  logic        idle, gnt_data, gnt_inst, rd_hs, wr_addr_done, wr_done;
  logic [31:0] araddr_q, awaddr_q, wdata_q, inst_rdata_q, data_rdata_q;
  logic [2:0]  arsize_q, awsize_q;
  logic [3:0]  arid_q, wstrb_q;
  logic        inst_ready_q, data_ready_q;

  axi_wr_channel u_wr (
    .clk         (clk),
    .rst         (rst),
    .start_i     (gnt_data & data_wr),
    .awready_i   (awready),
    .wready_i    (wready),
    .bvalid_i    (bvalid),
    .awvalid_o   (awvalid),
    .wvalid_o    (wvalid),
    .bready_o    (bready),
    .addr_done_o (wr_addr_done),
    .done_o      (wr_done)
  );

  // grant with data priority; a requester whose ready is pulsing this cycle is blocked
  always_comb begin
    idle     = state_q == S_IDLE;
    gnt_data = idle & data_req & ~data_ready_q;
    gnt_inst = idle & inst_req & ~inst_ready_q & ~gnt_data;
    rd_hs    = (state_q == S_RD_DATA) & rvalid & (rid == arid_q);
    stallreq = (inst_req & ~inst_ready) | (data_req & ~data_ready);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:         state_d = gnt_data ? (data_wr ? S_WR_ADDR_DATA : S_RD_ADDR) :
                                gnt_inst ? S_RD_ADDR : S_IDLE;
      S_RD_ADDR:      state_d = arready ? S_RD_DATA : S_RD_ADDR;
      S_RD_DATA:      state_d = rd_hs ? S_IDLE : S_RD_DATA;
      S_WR_ADDR_DATA: state_d = wr_addr_done ? S_WR_RESP : S_WR_ADDR_DATA;
      S_WR_RESP:      state_d = wr_done ? S_IDLE : S_WR_RESP;
      default:        state_d = S_IDLE;
    endcase
  end

  // read-channel handshake outputs follow the state directly
  always_comb begin
    arvalid = state_q == S_RD_ADDR;
    rready  = state_q == S_RD_DATA;
  end

  // latch attributes at grant, capture read data and raise the owner's ready pulse on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_NONE;
      araddr_q     <= '0;
      arsize_q     <= '0;
      arid_q       <= '0;
      awaddr_q     <= '0;
      awsize_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      if (gnt_data) begin
        owner_q <= OWN_DATA;
        if (data_wr) begin
          awaddr_q <= data_addr;
          awsize_q <= ax_size(data_size);
          wdata_q  <= data_wdata;
          wstrb_q  <= data_wstrb;
        end else begin
          araddr_q <= data_addr;
          arsize_q <= ax_size(data_size);
          arid_q   <= DATA_ID;
        end
      end else if (gnt_inst) begin
        owner_q  <= OWN_INST;
        araddr_q <= inst_addr;
        arsize_q <= SIZE_WORD;
        arid_q   <= INST_ID;
      end
      if (rd_hs) begin
        owner_q <= OWN_NONE;
        if (owner_q == OWN_INST) begin
          inst_rdata_q <= rdata;
          inst_ready_q <= 1'b1;
        end else begin
          data_rdata_q <= rdata;
          data_ready_q <= 1'b1;
        end
      end
      if (wr_done) begin
        owner_q      <= OWN_NONE;
        data_ready_q <= 1'b1;
      end
    end
  end

  assign arid       = arid_q;
  assign araddr     = araddr_q;
  assign arsize     = arsize_q;
  assign awaddr     = awaddr_q;
  assign awsize     = awsize_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign inst_ready = inst_ready_q;
  assign data_ready = data_ready_q;
endmodule

// File: tb/tb_sram_axi_arbiter.sv
// tb_sram_axi_arbiter: vector table, corner sequences and a randomized memory-model run for the arbiter
module tb_sram_axi_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_ready, data_req, data_wr, data_ready, stallreq;
  logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [3:0]  arid, rid, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    logic        is_inst;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] rd;
    logic [3:0]  e_id;
    logic [2:0]  e_size;
  } vec_t;
  vec_t vecs[7];

  logic [31:0] smem[logic [31:0]];
  logic [31:0] rmem[logic [31:0]];
  logic        ar_hs, r_hs, aw_hs, w_hs, b_hs, rd_pend, aw_got, w_got, b_started, drained;
  int          rdly, bdly, inst_wait, data_wait, n_done, pulses, bcnt;
  logic [31:0] rd_addr, c_awaddr, c_wdata;
  logic [3:0]  rd_id, c_wstrb;

  always #5 clk = ~clk;

  sram_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ready(data_ready),
    .stallreq(stallreq),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk(name, 32'({arvalid, rready, awvalid, wvalid, bready, inst_ready, data_ready}), 32'd0);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hA5A50F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i+:8] = nw[8*i+:8];
    return r;
  endfunction

  function automatic logic [31:0] srd(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rrd(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_word(a);
  endfunction

  task automatic run_vec(input vec_t v);
    if (v.is_inst) begin
      inst_req  = 1'b1;
      inst_addr = v.addr;
    end else begin
      data_req   = 1'b1;
      data_wr    = v.wr;
      data_size  = v.size;
      data_addr  = v.addr;
      data_wdata = v.wdat;
      data_wstrb = v.strb;
    end
    #1 chk("vec_stall_c0", 32'(stallreq), 32'd1);
    tick;
    if (v.wr) begin
      chk("vec_awvalid_wvalid", 32'({awvalid, wvalid, arvalid}), 32'b110);
      chk("vec_awaddr", awaddr, v.addr);
      chk("vec_awsize", 32'(awsize), 32'(v.e_size));
      chk("vec_wdata", wdata, v.wdat);
      chk("vec_wstrb", 32'(wstrb), 32'(v.strb));
      awready = 1'b1;
      wready  = 1'b1;
    end else begin
      chk("vec_arvalid", 32'({arvalid, awvalid, wvalid}), 32'b100);
      chk("vec_araddr", araddr, v.addr);
      chk("vec_arid", 32'(arid), 32'(v.e_id));
      chk("vec_arsize", 32'(arsize), 32'(v.e_size));
      arready = 1'b1;
    end
    tick;
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    if (v.wr) begin
      chk("vec_c2_bready", 32'({awvalid, wvalid, bready}), 32'b001);
      bvalid = 1'b1;
    end else begin
      chk("vec_c2_rready", 32'({arvalid, rready}), 32'b01);
      rvalid = 1'b1;
      rid    = v.e_id;
      rdata  = v.rd;
    end
    tick;
    rvalid = 1'b0;
    bvalid = 1'b0;
    chk("vec_c3_ready", 32'({inst_ready, data_ready}), v.is_inst ? 32'b10 : 32'b01);
    chk("vec_c3_stall", 32'(stallreq), 32'd0);
    if (!v.wr) chk("vec_c3_rdata", v.is_inst ? inst_rdata : data_rdata, v.rd);
    tick;
    chk_quiet("vec_c4_no_regrant");
    inst_req = 1'b0;
    data_req = 1'b0;
    tick;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 2'd0, 4'h0, 32'hBFC00000, 32'h0, 32'h3C080001, 4'd0, 3'd2};
    vecs[1] = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h80001004, 32'h0, 32'h8C420004, 4'd1, 3'd2};
    vecs[2] = '{1'b0, 1'b0, 2'd0, 4'h0, 32'h80000003, 32'h0, 32'h000000AB, 4'd1, 3'd0};
    vecs[3] = '{1'b0, 1'b0, 2'd1, 4'h0, 32'h80000006, 32'h0, 32'h1234ABCD, 4'd1, 3'd1};
    vecs[4] = '{1'b0, 1'b1, 2'd2, 4'hF, 32'h80002000, 32'hDEADBEEF, 32'h0, 4'd1, 3'd2};
    vecs[5] = '{1'b0, 1'b1, 2'd1, 4'h3, 32'h80002002, 32'h0000BEEF, 32'h0, 4'd1, 3'd1};
    vecs[6] = '{1'b1, 1'b0, 2'd3, 4'h0, 32'hBFC00004, 32'h0, 32'h27BDFFE8, 4'd0, 3'd2};
    rst = 1'b1;
    {inst_req, data_req, data_wr, arready, rvalid, awready, wready, bvalid} = '0;
    inst_addr = '0; data_addr = '0; data_wdata = '0; data_size = '0; data_wstrb = '0;
    rid = '0; rdata = '0;
    tick;
    tick;
    chk_quiet("reset_handshakes");
    chk("reset_araddr", araddr, 32'd0);
    chk("reset_awaddr", awaddr, 32'd0);
    chk("reset_wdata", wdata, 32'd0);
    chk("reset_attrs", 32'({wstrb, arsize, awsize, arid}), 32'd0);
    chk("reset_rdata", inst_rdata | data_rdata, 32'd0);
    rst = 1'b0;
    tick;
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    inst_req = 1'b1; inst_addr = 32'hBFC00010;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80001004;
    tick;
    chk("sim_data_first", 32'({arvalid, arid}), {27'd0, 1'b1, 4'd1});
    chk("sim_data_araddr", araddr, 32'h80001004);
    arready = 1'b1;
    tick;
    arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h11112222;
    tick;
    rvalid = 1'b0;
    chk("sim_data_ready_first", 32'({inst_ready, data_ready}), 32'b01);
    chk("sim_data_rdata", data_rdata, 32'h11112222);
    tick;
    chk("sim_inst_next", 32'({arvalid, arid}), {27'd0, 1'b1, 4'd0});
    chk("sim_inst_araddr", araddr, 32'hBFC00010);
    chk("sim_no_data_repulse", 32'(data_ready), 32'd0);
    data_req = 1'b0; arready = 1'b1;
    tick;
    arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h33334444;
    tick;
    rvalid = 1'b0;
    chk("sim_inst_ready", 32'({inst_ready, data_ready}), 32'b10);
    chk("sim_inst_rdata", inst_rdata, 32'h33334444);
    chk("sim_data_rdata_hold", data_rdata, 32'h11112222);
    inst_req = 1'b0;
    tick;

    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_wstrb = 4'b0100;
    data_wdata = 32'h00AB0000; data_addr = 32'h80003002;
    tick;
    chk("byte_c1_valids", 32'({awvalid, wvalid, bready}), 32'b110);
    chk("byte_awsize", 32'(awsize), 32'd0);
    chk("byte_wstrb", 32'(wstrb), 32'b0100);
    chk("byte_wdata", wdata, 32'h00AB0000);
    wready = 1'b1;
    tick;
    wready = 1'b0;
    chk("byte_c2_w_dropped", 32'({awvalid, wvalid, bready}), 32'b100);
    tick;
    chk("byte_c3_aw_waiting", 32'({awvalid, wvalid, bready}), 32'b100);
    awready = 1'b1;
    tick;
    awready = 1'b0;
    chk("byte_c4_bready", 32'({awvalid, wvalid, bready, data_ready}), 32'b0010);
    bvalid = 1'b1;
    tick;
    bvalid = 1'b0;
    chk("byte_c5_ready", 32'({bready, data_ready}), 32'b01);
    data_req = 1'b0;
    tick;
    chk("byte_c6_single_pulse", 32'(data_ready), 32'd0);

    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF;
    data_wdata = 32'hCAFEF00D; data_addr = 32'h80003010;
    tick;
    chk("same_c1_bready_low", 32'({awvalid, wvalid, bready}), 32'b110);
    awready = 1'b1; wready = 1'b1;
    tick;
    awready = 1'b0; wready = 1'b0;
    pulses = 0; bcnt = 0;
    for (int k = 2; k <= 12; k++) begin
      if (bready) bcnt++;
      if (data_ready) pulses++;
      if (k == 7) bvalid = 1'b1;
      if (k == 8) begin
        bvalid   = 1'b0;
        data_req = 1'b0;
      end
      tick;
    end
    chk("same_one_pulse", 32'(pulses), 32'd1);
    chk("same_bready_cycles", 32'(bcnt), 32'd6);

    inst_req = 1'b1; inst_addr = 32'hBFC00020;
    tick;
    for (int k = 0; k < 10; k++) begin
      chk("bp_arvalid", 32'(arvalid), 32'd1);
      chk("bp_araddr", araddr, 32'hBFC00020);
      chk("bp_stall", 32'(stallreq), 32'd1);
      chk("bp_no_ready", 32'({inst_ready, data_ready, rready}), 32'd0);
      tick;
    end
    arready = 1'b1;
    tick;
    arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h55AA55AA;
    tick;
    rvalid = 1'b0;
    chk("bp_done", 32'(inst_ready), 32'd1);
    chk("bp_rdata", inst_rdata, 32'h55AA55AA);
    inst_req = 1'b0;
    tick;

    inst_req = 1'b1; inst_addr = 32'hBFC00030;
    tick;
    arready = 1'b1;
    tick;
    arready = 1'b0;
    chk("rst_in_rd_data", 32'(rready), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0; inst_req = 1'b0;
    chk_quiet("rst_outputs_low");
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk_quiet("rst_no_stray");
    end

    smem.delete(); rmem.delete();
    {ar_hs, r_hs, aw_hs, w_hs, b_hs, rd_pend, aw_got, w_got, b_started, drained} = '0;
    rdly = 0; bdly = 0; inst_wait = 0; data_wait = 0; n_done = 0;
    rd_addr = '0; rd_id = '0; c_awaddr = '0; c_wdata = '0; c_wstrb = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick;
      chk("rnd_stall", 32'(stallreq), 32'((inst_req & ~inst_ready) | (data_req & ~data_ready)));
      if (ar_hs) begin arready = 1'b0; ar_hs = 1'b0; rd_pend = 1'b1; rdly = int'($urandom_range(0, 3)); end
      if (r_hs) begin rvalid = 1'b0; r_hs = 1'b0; rd_pend = 1'b0; end
      if (aw_hs) begin awready = 1'b0; aw_hs = 1'b0; aw_got = 1'b1; end
      if (w_hs) begin wready = 1'b0; w_hs = 1'b0; w_got = 1'b1; end
      if (b_hs) begin bvalid = 1'b0; b_hs = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_started = 1'b0; end
      if (inst_ready) begin
        chk("rnd_inst_req_held", 32'(inst_req), 32'd1);
        chk("rnd_inst_rdata", inst_rdata, rrd(inst_addr));
        inst_req = 1'b0;
        n_done++;
      end else if (inst_req) begin
        inst_wait++;
        if (inst_wait == 400) begin
          n_chk++; n_fail++;
          $display("FAIL rnd_inst_timeout: got no inst_ready, expected one within 400 cycles");
          inst_req = 1'b0;
        end
      end else if (cyc < 2500 && $urandom_range(0, 3) == 0) begin
        inst_req  = 1'b1;
        inst_wait = 0;
        inst_addr = 32'hBFC00000 + 32'($urandom_range(0, 7)) * 32'd4;
      end
      if (data_ready) begin
        chk("rnd_data_req_held", 32'(data_req), 32'd1);
        if (data_wr) rmem[data_addr] = merge(rrd(data_addr), data_wdata, data_wstrb);
        else chk("rnd_data_rdata", data_rdata, rrd(data_addr));
        data_req = 1'b0;
        n_done++;
      end else if (data_req) begin
        data_wait++;
        if (data_wait == 400) begin
          n_chk++; n_fail++;
          $display("FAIL rnd_data_timeout: got no data_ready, expected one within 400 cycles");
          data_req = 1'b0;
        end
      end else if (cyc < 2500 && $urandom_range(0, 2) == 0) begin
        data_req   = 1'b1;
        data_wait  = 0;
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 2));
        data_addr  = 32'h80000000 + 32'($urandom_range(0, 7)) * 32'd4;
        data_wdata = $urandom;
        data_wstrb = 4'($urandom_range(1, 15));
      end
      if (arvalid && $urandom_range(0, 2) == 0) begin
        arready = 1'b1; ar_hs = 1'b1; rd_addr = araddr; rd_id = arid;
        if (arid == 4'd1) begin
          chk("rnd_ar_data_addr", araddr, data_addr);
          chk("rnd_ar_data_size", 32'(arsize), 32'({1'b0, data_size}));
        end else begin
          chk("rnd_ar_inst_id", 32'(arid), 32'd0);
          chk("rnd_ar_inst_addr", araddr, inst_addr);
          chk("rnd_ar_inst_size", 32'(arsize), 32'd2);
        end
      end
      if (rd_pend && !rvalid) begin
        if (rdly == 0) begin rvalid = 1'b1; rid = rd_id; rdata = srd(rd_addr); end
        else rdly--;
      end
      if (rvalid && rready) r_hs = 1'b1;
      if (awvalid && !aw_got && $urandom_range(0, 1) == 0) begin
        awready = 1'b1; aw_hs = 1'b1; c_awaddr = awaddr;
        chk("rnd_awaddr", awaddr, data_addr);
        chk("rnd_awsize", 32'(awsize), 32'({1'b0, data_size}));
      end
      if (wvalid && !w_got && $urandom_range(0, 1) == 0) begin
        wready = 1'b1; w_hs = 1'b1; c_wdata = wdata; c_wstrb = wstrb;
        chk("rnd_wdata", wdata, data_wdata);
        chk("rnd_wstrb", 32'(wstrb), 32'(data_wstrb));
      end
      if (aw_got && w_got && !b_started) begin
        b_started = 1'b1;
        bdly = int'($urandom_range(0, 4));
        smem[c_awaddr] = merge(srd(c_awaddr), c_wdata, c_wstrb);
      end
      if (b_started && !bvalid) begin
        if (bdly == 0) bvalid = 1'b1;
        else bdly--;
      end
      if (bvalid && bready) b_hs = 1'b1;
      if (cyc >= 2500 && !inst_req && !data_req) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) begin
      n_chk++; n_fail++;
      $display("FAIL rnd_drain: got requests still pending, expected idle by cycle 4000");
    end
    chk("rnd_completions", 32'(n_done > 20), 32'd1);
    {arready, rvalid, awready, wready, bvalid} = '0;
    tick;
    chk_quiet("end_idle");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
